// File: rtl/ins_exec_seq_if.sv
// Instruction fetch handshake between the sequencer (master) and instruction memory (slave).
interface ins_exec_seq_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ins_exec_seq.sv
// Multi-cycle RV32I sequencer: fetch -> decode -> execute -> writeback, owning PC and trap state.
// Execute-unit requests are captured in EXEC and committed in a separate WB cycle.
module ins_exec_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ins_exec_seq_if.master       mem,
  output logic [31:0]          o_ins,
  input  logic                 i_ins_illegal,
  output logic                 o_exec_op,
  input  logic                 i_ex_pc_w_op,
  input  logic [31:0]          i_ex_pc_w_val,
  input  logic                 i_ex_reg_w_op,
  input  logic [4:0]           i_ex_reg_w_idx,
  input  logic [31:0]          i_ex_reg_w_val,
  output logic                 o_rf_w_en,
  output logic [4:0]           o_rf_w_idx,
  output logic [31:0]          o_rf_w_val,
  output logic [31:0]          o_pc,
  output logic                 o_retire,
  output logic                 o_trap,
  output logic [1:0]           o_trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [7:0]  r_cnt;
  logic [1:0]  r_cause;

  logic        r_cap_pc_op;
  logic [31:0] r_cap_pc_val;
  logic        r_cap_reg_op;
  logic [4:0]  r_cap_idx;
  logic [31:0] r_cap_val;

  logic        w_req;
  logic        w_wr;
  logic [7:0]  w_cnt_nxt;

  // Request is masked while rst_n is low so an ack during reset can never be consumed.
  assign w_req     = rst_n && ((r_state == S_FETCH) || (r_state == S_WAIT));
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_wr      = (r_state == S_WB) && r_cap_reg_op && (r_cap_idx != 5'd0);

  assign mem.mem_req  = w_req;
  assign mem.mem_addr = w_req ? r_pc : 32'h0;

  assign o_ins        = r_ins;
  assign o_exec_op    = (r_state == S_EXEC);
  assign o_rf_w_en    = w_wr;
  assign o_rf_w_idx   = w_wr ? r_cap_idx : 5'd0;
  assign o_rf_w_val   = w_wr ? r_cap_val : 32'h0;
  assign o_pc         = r_pc;
  assign o_retire     = (r_state == S_WB);
  assign o_trap       = (r_state == S_TRAP);
  assign o_trap_cause = r_cause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ins   <= 32'h0;
      r_cnt   <= 8'd0;
      r_cause <= 2'b00;
    end else begin
      case (r_state)
        // The counter holds cycles already spent with req high and no ack.
        S_FETCH, S_WAIT: begin
          if (mem.mem_ack) begin
            r_ins   <= mem.mem_rdata;
            r_state <= S_DECODE;
          end else if (w_cnt_nxt == TIMEOUT) begin
            r_cause <= 2'b11;
            r_state <= S_TRAP;
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= S_WAIT;
          end
        end
        S_DECODE: begin
          if (i_ins_illegal) begin
            r_cause <= 2'b01;
            r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_ex_pc_w_op && (i_ex_pc_w_val[1:0] != 2'b00)) begin
            r_cause <= 2'b10;
            r_state <= S_TRAP;
          end else begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= r_cap_pc_op ? r_cap_pc_val : r_pc + 32'd4;
          r_cnt   <= 8'd0;
          r_state <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Execute results are only meaningful during the strobe cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC) begin
      r_cap_pc_op  <= i_ex_pc_w_op;
      r_cap_pc_val <= i_ex_pc_w_val;
      r_cap_reg_op <= i_ex_reg_w_op;
      r_cap_idx    <= i_ex_reg_w_idx;
      r_cap_val    <= i_ex_reg_w_val;
    end
  end

endmodule

// File: tb/tb_ins_exec_seq.sv
// Directed bench for ins_exec_seq: fetch handshake, writeback, PC update, traps and reset.
module tb_ins_exec_seq;
  logic        clk;
  logic        rst_n;
  logic [31:0] ins;
  logic        ins_illegal;
  logic        exec_op;
  logic        ex_pc_w_op;
  logic [31:0] ex_pc_w_val;
  logic        ex_reg_w_op;
  logic [4:0]  ex_reg_w_idx;
  logic [31:0] ex_reg_w_val;
  logic        rf_w_en;
  logic [4:0]  rf_w_idx;
  logic [31:0] rf_w_val;
  logic [31:0] pc;
  logic        retire;
  logic        trap;
  logic [1:0]  trap_cause;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  ins_exec_seq_if mif();

  ins_exec_seq #(.RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem(mif),
    .o_ins(ins), .i_ins_illegal(ins_illegal), .o_exec_op(exec_op),
    .i_ex_pc_w_op(ex_pc_w_op), .i_ex_pc_w_val(ex_pc_w_val),
    .i_ex_reg_w_op(ex_reg_w_op), .i_ex_reg_w_idx(ex_reg_w_idx), .i_ex_reg_w_val(ex_reg_w_val),
    .o_rf_w_en(rf_w_en), .o_rf_w_idx(rf_w_idx), .o_rf_w_val(rf_w_val),
    .o_pc(pc), .o_retire(retire), .o_trap(trap), .o_trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic pw, input logic [31:0] pv, input logic rw,
                        input logic [4:0] ri, input logic [31:0] rv);
    ex_pc_w_op = pw; ex_pc_w_val = pv; ex_reg_w_op = rw; ex_reg_w_idx = ri; ex_reg_w_val = rv;
  endtask

  // Starts in FETCH, ends at the first DECODE cycle.
  task automatic do_fetch(input logic [31:0] word, input int delay);
    for (int i = 0; i < delay; i++) begin
      mif.mem_ack = 1'b0; tick();
    end
    mif.mem_ack = 1'b1; mif.mem_rdata = word; tick();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mif.mem_ack = 1'b0; ins_illegal = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0; ins_illegal = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick(); tick();
    checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mif.mem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", pc); end
    checks++; if (ins !== 32'h0) begin failures++; $display("FAIL rst_ins got=%h exp=00000000", ins); end
    checks++; if ({trap, retire, rf_w_en, exec_op} !== 4'b0) begin failures++; $display("FAIL rst_ctrl got=%b exp=0000", {trap, retire, rf_w_en, exec_op}); end
    checks++; if (trap_cause !== 2'b00) begin failures++; $display("FAIL rst_cause got=%b exp=00", trap_cause); end
    rst_n = 1'b1;
    #1;
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_release_fetch got=%b/%h exp=1/00000000", mif.mem_req, mif.mem_addr); end
  endtask

  task automatic test_addi();
    set_ex(1'b0, 32'h0, 1'b1, 5'd5, 32'h2A);
    mif.mem_ack = 1'b0; tick();
    checks++; if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL addi_wait_req got=%b exp=1", mif.mem_req); end
    mif.mem_ack = 1'b0; tick();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h02A0_0293; tick();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    checks++; if (ins !== 32'h02A0_0293) begin failures++; $display("FAIL addi_ins got=%h exp=02a00293", ins); end
    checks++; if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL addi_req_drop got=%b exp=0", mif.mem_req); end
    tick();
    checks++; if (exec_op !== 1'b1) begin failures++; $display("FAIL addi_exec_op got=%b exp=1", exec_op); end
    tick();
    checks++; if ({rf_w_en, rf_w_idx, rf_w_val} !== {1'b1, 5'd5, 32'h2A}) begin failures++; $display("FAIL addi_rf got=%b/%0d/%h exp=1/5/0000002a", rf_w_en, rf_w_idx, rf_w_val); end
    checks++; if (retire !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL addi_wb got=%b/%h exp=1/00000000", retire, pc); end
    tick();
    checks++; if (pc !== 32'h4 || mif.mem_addr !== 32'h4) begin failures++; $display("FAIL addi_next got=%h/%h exp=00000004", pc, mif.mem_addr); end
    checks++; if (retire !== 1'b0 || rf_w_en !== 1'b0) begin failures++; $display("FAIL addi_pulse got=%b/%b exp=0/0", retire, rf_w_en); end
  endtask

  task automatic test_pc_sequence();
    set_ex(1'b0, 32'h0, 1'b0, 5'd7, 32'h55);
    for (int k = 0; k < 3; k++) begin
      do_fetch(NOP, 0); tick(); tick();
      checks++; if (rf_w_en !== 1'b0) begin failures++; $display("FAIL seq_no_write got=%b exp=0", rf_w_en); end
      tick();
    end
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL seq_pc got=%h exp=00000010", pc); end
  endtask

  task automatic test_jal();
    set_ex(1'b1, 32'h100, 1'b1, 5'd1, 32'h14);
    do_fetch(32'h0F00_00EF, 0); tick(); tick();
    checks++; if ({rf_w_en, rf_w_idx, rf_w_val} !== {1'b1, 5'd1, 32'h14}) begin failures++; $display("FAIL jal_rf got=%b/%0d/%h exp=1/1/00000014", rf_w_en, rf_w_idx, rf_w_val); end
    tick();
    checks++; if (pc !== 32'h100 || mif.mem_addr !== 32'h100) begin failures++; $display("FAIL jal_pc got=%h/%h exp=00000100", pc, mif.mem_addr); end
  endtask

  task automatic test_x0_write();
    set_ex(1'b0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    do_fetch(32'h0010_0013, 1); tick(); tick();
    checks++; if (rf_w_en !== 1'b0) begin failures++; $display("FAIL x0_rf_w_en got=%b exp=0", rf_w_en); end
    checks++; if (retire !== 1'b1) begin failures++; $display("FAIL x0_retire got=%b exp=1", retire); end
    tick();
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL x0_pc got=%h exp=00000104", pc); end
  endtask

  task automatic test_misaligned();
    set_ex(1'b1, 32'h102, 1'b1, 5'd3, 32'h7);
    do_fetch(32'h0000_0063, 0); tick();
    checks++; if (exec_op !== 1'b1) begin failures++; $display("FAIL mis_exec_op got=%b exp=1", exec_op); end
    tick();
    checks++; if (trap !== 1'b1 || trap_cause !== 2'b10) begin failures++; $display("FAIL mis_trap got=%b/%b exp=1/10", trap, trap_cause); end
    checks++; if ({rf_w_en, retire, mif.mem_req} !== 3'b000) begin failures++; $display("FAIL mis_quiet got=%b exp=000", {rf_w_en, retire, mif.mem_req}); end
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL mis_pc got=%h exp=00000104", pc); end
    tick(); tick(); tick();
    checks++; if (trap !== 1'b1 || mif.mem_req !== 1'b0 || pc !== 32'h104) begin failures++; $display("FAIL mis_sticky got=%b/%b/%h exp=1/0/00000104", trap, mif.mem_req, pc); end
  endtask

  task automatic test_ack_at_limit();
    set_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      mif.mem_ack = 1'b0; tick();
    end
    checks++; if (mif.mem_req !== 1'b1 || trap !== 1'b0) begin failures++; $display("FAIL lim_req16 got=%b/%b exp=1/0", mif.mem_req, trap); end
    mif.mem_ack = 1'b1; mif.mem_rdata = NOP; tick();
    mif.mem_ack = 1'b0;
    checks++; if (trap !== 1'b0 || ins !== NOP) begin failures++; $display("FAIL lim_accept got=%b/%h exp=0/00000013", trap, ins); end
    tick(); tick(); tick();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL lim_pc got=%h exp=00000004", pc); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mif.mem_req === 1'b1) req_cycles++;
      tick();
    end
    checks++; if (req_cycles != 16) begin failures++; $display("FAIL to_req_cycles got=%0d exp=16", req_cycles); end
    checks++; if (trap !== 1'b1 || trap_cause !== 2'b11) begin failures++; $display("FAIL to_trap got=%b/%b exp=1/11", trap, trap_cause); end
    checks++; if (mif.mem_req !== 1'b0 || pc !== 32'h4) begin failures++; $display("FAIL to_req_pc got=%b/%h exp=0/00000004", mif.mem_req, pc); end
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678; tick();
    mif.mem_ack = 1'b0;
    checks++; if (ins !== NOP || trap !== 1'b1 || trap_cause !== 2'b11) begin failures++; $display("FAIL to_late_ack got=%h/%b/%b exp=00000013/1/11", ins, trap, trap_cause); end
  endtask

  task automatic test_illegal();
    checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin failures++; $display("FAIL ill_pre_clear got=%b/%b exp=0/00", trap, trap_cause); end
    ins_illegal = 1'b1;
    do_fetch(32'hFFFF_FFFF, 0);
    checks++; if (trap !== 1'b0 || exec_op !== 1'b0) begin failures++; $display("FAIL ill_decode got=%b/%b exp=0/0", trap, exec_op); end
    tick();
    ins_illegal = 1'b0;
    checks++; if (trap !== 1'b1 || trap_cause !== 2'b01) begin failures++; $display("FAIL ill_trap got=%b/%b exp=1/01", trap, trap_cause); end
    checks++; if (exec_op !== 1'b0 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL ill_quiet got=%b/%b exp=0/0", exec_op, mif.mem_req); end
  endtask

  task automatic test_reset_mid_wait();
    set_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    do_fetch(NOP, 0); tick(); tick(); tick();
    mif.mem_ack = 1'b0; tick();
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h4) begin failures++; $display("FAIL rmw_wait got=%b/%h exp=1/00000004", mif.mem_req, mif.mem_addr); end
    rst_n = 1'b0; mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF; tick();
    checks++; if (pc !== 32'h0 || ins !== 32'h0 || trap !== 1'b0 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL rmw_reset got=%h/%h/%b/%b exp=00000000/00000000/0/0", pc, ins, trap, mif.mem_req); end
    mif.mem_ack = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0) begin failures++; $display("FAIL rmw_fetch got=%b/%h exp=1/00000000", mif.mem_req, mif.mem_addr); end
    tick();
    checks++; if (ins !== 32'h0) begin failures++; $display("FAIL rmw_ack_dropped got=%h exp=00000000", ins); end
  endtask

  initial begin
    rst_n = 1'b0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'h0;
    ins_illegal = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    test_reset();
    test_addi();
    test_pc_sequence();
    test_jal();
    test_x0_write();
    test_misaligned();
    do_reset();
    test_ack_at_limit();
    test_timeout();
    do_reset();
    test_illegal();
    do_reset();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
